// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: serialises a byte-stream PAL bitstream onto cfg_bit/cfg_clk and gates pal_enable
module pal_cfg_loader #(
   parameter int NUM_INPUTS        = 8,
   parameter int NUM_INTERM_STAGES = 11,
   parameter int NUM_OUTPUTS       = 8,
   parameter int HALF_PERIOD       = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       enable_req,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       cfg_bit,
   output logic       cfg_clk,
   output logic       pal_enable,
   output logic       busy,
   output logic       done
);
   localparam int BITSTREAM_LEN = 2*NUM_INPUTS*NUM_INTERM_STAGES + NUM_INTERM_STAGES*NUM_OUTPUTS;
   localparam int CW = $clog2(BITSTREAM_LEN + 1);
   localparam int PW = $clog2(HALF_PERIOD + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(BITSTREAM_LEN);
   localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOW = 3'd2, HIGH = 3'd3, FINISH = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]    bib_q, bib_d;
   logic [PW-1:0] ph_q, ph_d;
   logic          configured_q, configured_d;
   logic          cfg_bit_q, cfg_bit_d;
   logic          cfg_clk_q, cfg_clk_d;
   logic          byte_ready_q, byte_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pal_enable_q, pal_enable_d;
   logic          ph_end;

   // next state, shift datapath and registered-output decode; abort overrides everything
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      bib_d        = bib_q;
      configured_d = configured_q;
      ph_end       = ph_q == PH_LAST;
      if (abort) begin
         state_d      = IDLE;
         configured_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_d      = FETCH;
               configured_d = 1'b0;
               bit_cnt_d    = '0;
            end
            FETCH: if (byte_valid) begin
               shreg_d = byte_data;
               bib_d   = '0;
               state_d = LOW;
            end
            LOW: if (ph_end) state_d = HIGH;
            HIGH: if (ph_end) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               shreg_d   = {1'b0, shreg_q[7:1]};
               bib_d     = bib_q + 1'b1;
               state_d   = bit_cnt_d == LAST_BIT ? FINISH : bib_q == 3'd7 ? FETCH : LOW;
            end
            default: state_d = IDLE;
         endcase
      end
      if (state_d == FINISH) configured_d = 1'b1;
      ph_d         = state_d != state_q ? '0 : ph_q + 1'b1;
      byte_ready_d = state_d == FETCH;
      cfg_clk_d    = state_d == HIGH;
      busy_d       = state_d == FETCH || state_d == LOW || state_d == HIGH;
      done_d       = state_d == FINISH;
      cfg_bit_d    = state_d == LOW && state_q != LOW ? shreg_d[0] : cfg_bit_q;
      pal_enable_d = configured_d & ~busy_d & enable_req;
   end

   // state and output registers, cleared asynchronously on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         bib_q        <= '0;
         ph_q         <= '0;
         configured_q <= 1'b0;
         cfg_bit_q    <= 1'b0;
         cfg_clk_q    <= 1'b0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pal_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         bib_q        <= bib_d;
         ph_q         <= ph_d;
         configured_q <= configured_d;
         cfg_bit_q    <= cfg_bit_d;
         cfg_clk_q    <= cfg_clk_d;
         byte_ready_q <= byte_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pal_enable_q <= pal_enable_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign cfg_bit    = cfg_bit_q;
   assign cfg_clk    = cfg_clk_q;
   assign pal_enable = pal_enable_q;
   assign busy       = busy_q;
   assign done       = done_q;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: scoreboard bench for pal_cfg_loader at default and 5-output geometries
module tb_pal_cfg_loader;
   logic       clk = 1'b0, rst_n = 1'b0, abort = 1'b0, enable_req = 1'b0;
   logic [1:0] start = '0, byte_valid = '0;
   logic [1:0] byte_ready, cfg_bit, cfg_clk, pal_enable, busy, done;
   logic [7:0] byte_data = '0;
   int         n_tests = 0, n_fail = 0;
   int         sel = 0, edges = 0, dones = 0;
   logic       prev_clk = 1'b0, prev_bit = 1'b0;
   bit         exp_q[$];

   always #5 clk = ~clk;

   pal_cfg_loader #(.HALF_PERIOD(2)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .enable_req(enable_req),
      .byte_data(byte_data), .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]),
      .cfg_bit(cfg_bit[0]), .cfg_clk(cfg_clk[0]), .pal_enable(pal_enable[0]),
      .busy(busy[0]), .done(done[0]));

   pal_cfg_loader #(.NUM_OUTPUTS(5), .HALF_PERIOD(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .enable_req(enable_req),
      .byte_data(byte_data), .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]),
      .cfg_bit(cfg_bit[1]), .cfg_clk(cfg_clk[1]), .pal_enable(pal_enable[1]),
      .busy(busy[1]), .done(done[1]));

   function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endfunction

   // score each cfg_clk rising edge of the selected DUT against the queued bits
   always @(negedge clk) begin
      if (rst_n) begin
         if (cfg_clk[sel] && !prev_clk) begin
            edges++;
            if (exp_q.size() == 0) chk("extra_edge", 1, 0);
            else chk("cfg_bit", cfg_bit[sel], exp_q.pop_front());
         end
         if (cfg_clk[sel]) chk("bit_hold", cfg_bit[sel], prev_bit);
         if (busy[sel]) chk("en_busy", pal_enable[sel], 0);
         if (done[sel]) dones++;
      end
      prev_clk <= cfg_clk[sel];
      prev_bit <= cfg_bit[sel];
   end

   task automatic wait_ready();
      int t = 0;
      while (!byte_ready[sel] && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("ready_seen", byte_ready[sel], 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy[sel] && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("busy_fall", busy[sel], 0);
   endtask

   task automatic pulse_start();
      start[sel] = 1'b1;
      @(negedge clk);
      start[sel] = 1'b0;
   endtask

   task automatic send(input int nbytes, input int len, input int mode, input int gap_at);
      int gidx = 0;
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         if (i == gap_at) begin
            wait_ready();
            for (int k = 0; k < 20; k++) begin
               chk("gap_clk", cfg_clk[sel], 0);
               chk("gap_ready", byte_ready[sel], 1);
               start[sel] = k == 10;
               @(negedge clk);
            end
            start[sel] = 1'b0;
            chk("gap_busy", busy[sel], 1);
         end
         if (mode == 0) b = i < 6 ? 8'hFF : i == 6 ? 8'h7F : i == nbytes - 1 ? 8'h80 : 8'h00;
         else b = 8'($urandom_range(0, 255)) | (i == nbytes - 1 ? 8'h80 : 8'h00);
         for (int k = 0; k < 8; k++) if (gidx + k < len) exp_q.push_back(b[k]);
         gidx += 8;
         byte_data = b;
         byte_valid[sel] = 1'b1;
         wait_ready();
         @(negedge clk);
         byte_valid[sel] = 1'b0;
      end
   endtask

   task automatic run_pass(input int nbytes, input int len, input int mode, input int gap_at);
      edges = 0;
      dones = 0;
      pulse_start();
      chk("en_after_start", pal_enable[sel], 0);
      send(nbytes, len, mode, gap_at);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("edge_count", edges, len);
      chk("done_once", dones, 1);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int t, e;
      repeat (3) @(negedge clk);
      chk("rst_ready", byte_ready, 0);
      chk("rst_bit", cfg_bit, 0);
      chk("rst_clk", cfg_clk, 0);
      chk("rst_en", pal_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // fixed pattern, full default bitstream
      run_pass(33, 264, 0, -1);
      chk("en_idle_off", pal_enable[0], 0);
      // enable follows request once configured
      enable_req = 1'b1;
      @(negedge clk);
      chk("en_on", pal_enable[0], 1);
      enable_req = 1'b0;
      @(negedge clk);
      chk("en_off", pal_enable[0], 0);
      enable_req = 1'b1;
      @(negedge clk);
      chk("en_on2", pal_enable[0], 1);
      // restart with random bytes, stalled stream and an ignored start
      run_pass(33, 264, 1, 12);
      @(negedge clk);
      chk("en_back", pal_enable[0], 1);
      // abort after 100 bits
      edges = 0;
      dones = 0;
      pulse_start();
      send(13, 264, 1, -1);
      t = 0;
      while (edges < 100 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("reach_100", edges >= 100, 1);
      abort = 1'b1;
      @(negedge clk);
      chk("abort_clk", cfg_clk[0], 0);
      chk("abort_busy", busy[0], 0);
      chk("abort_ready", byte_ready[0], 0);
      @(negedge clk);
      abort = 1'b0;
      exp_q.delete();
      e = edges;
      repeat (6) @(negedge clk);
      chk("abort_no_edge", edges, e);
      chk("abort_en", pal_enable[0], 0);
      chk("abort_no_done", dones, 0);
      // five-output geometry: 231 bits, last byte bit 7 never clocked
      sel = 1;
      run_pass(29, 231, 1, -1);
      sel = 0;
      // reset during a HIGH phase
      edges = 0;
      pulse_start();
      send(3, 264, 1, -1);
      t = 0;
      while (!cfg_clk[0] && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("high_seen", cfg_clk[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_clk", cfg_clk[0], 0);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_ready", byte_ready[0], 0);
      chk("mid_rst_bit", cfg_bit[0], 0);
      chk("mid_rst_en", pal_enable[0], 0);
      chk("mid_rst_done", done[0], 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", busy[0], 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
